// File: rtl/imem_types.sv
// Shared types and constants for the instruction-memory responder.
package imem_types;

  localparam int          DEFAULT_DEPTH = 64;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
module imem_array #(
  parameter int DEPTH = imem_types::DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  // NOTE: storage has no reset; preloaded contents must survive reset_n.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with preload port and response counter.
module imem_responder
  import imem_types::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     instr_read,
  input  logic [31:0]              instr_mem_address,
  output logic                     instr_mem_resp,
  output logic [31:0]              in,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     busy,
  output logic [15:0]              resp_count
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_e      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr, w_addr_next;
  logic [31:0] r_in;
  logic [15:0] r_count;
  logic        w_capture;

  logic [31:0] w_rd_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_word;
  logic        w_in_range;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_addr_next = r_addr;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (instr_read) begin
          w_addr_next = instr_mem_address;
          if (LATENCY == 1) begin
            w_next    = RESP;
            w_capture = 1'b1;
          end else begin
            w_next     = WAIT;
            w_cnt_next = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!instr_read) begin
          w_next = IDLE;
        end else if (instr_mem_address != r_addr) begin
          // Requester retargeted mid-flight: restart the latency window.
          w_addr_next = instr_mem_address;
          w_cnt_next  = CNT_LOAD;
        end else if (r_cnt == 4'd0) begin
          w_next    = RESP;
          w_capture = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // From IDLE the address is latched on the capture edge itself, so read the live input.
  assign w_rd_addr  = (r_state == IDLE) ? instr_mem_address : r_addr;
  assign w_in_range = (w_rd_addr >> 2) < 32'(DEPTH);
  assign w_word     = w_in_range ? w_rdata : NOP;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (w_rd_addr[AW+1:2]),
    .rdata (w_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_in    <= 32'd0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      if (w_capture)         r_in    <= w_word;
      if (r_state == RESP)   r_count <= r_count + 16'd1;
    end
  end

  assign instr_mem_resp = (r_state == RESP);
  assign busy           = (r_state != IDLE);
  assign in             = r_in;
  assign resp_count     = r_count;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: vector table plus hand-written corner sequences.
module tb_imem_responder;

  localparam int          DEPTH = 64;
  localparam int          LAT   = 2;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_read = 1'b0;
  logic [31:0] instr_mem_address = 32'd0;
  logic        instr_mem_resp;
  logic [31:0] in;
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = 6'd0;
  logic [31:0] load_data = 32'd0;
  logic        busy;
  logic [15:0] resp_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb [$];
  logic [31:0] tb_mem [DEPTH];
  logic [15:0] exp_count = 16'd0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [7];

  imem_responder #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .in                (in),
    .load_en           (load_en),
    .load_addr         (load_addr),
    .load_data         (load_data),
    .busy              (busy),
    .resp_count        (resp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (instr_mem_resp) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {31'd0, instr_mem_resp}, 32'd0);
      end else begin
        check("resp_data", in, sb.pop_front());
        exp_count = exp_count + 16'd1;
      end
    end
  end

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_mem_resp && n < budget);
    if (!instr_mem_resp) check("pulse_timeout", {31'd0, instr_mem_resp}, 32'd1);
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 6'(idx); load_data = data;
    tb_mem[idx] = data;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    int n;
    sb.push_back(exp);
    @(posedge clk); #1;
    instr_read = 1'b1; instr_mem_address = addr;
    wait_pulse(20, n);
    check({name, "_latency"}, n, LAT + 1);
    instr_read = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    return ((addr >> 2) >= DEPTH) ? NOP_W : tb_mem[addr[7:2]];
  endfunction

  initial begin
    int n;
    logic [31:0] held;
    logic [15:0] cnt_before;
    logic [31:0] prog [6];
    prog = '{32'h000170b3, 32'h00100093, 32'h00208113,
             32'h002081b3, 32'h40110233, 32'h0000006f};

    #12;
    check("rst_resp", {31'd0, instr_mem_resp}, 32'd0);
    check("rst_in", in, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, resp_count}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      load_word(i, (i < 6) ? prog[i] : (32'hA500_0000 | 32'(i)));

    // Basic fetch of word 0
    fetch(32'h0, 32'h000170b3, "first_fetch");
    @(negedge clk);
    check("first_count", {16'd0, resp_count}, 32'd1);
    check("in_holds", in, 32'h000170b3);

    vecs = '{
      '{32'h0000_0000, 32'h000170b3},
      '{32'h0000_0007, 32'h00100093},
      '{32'h0000_0008, 32'h00208113},
      '{32'h0000_00FC, 32'hA500_003F},
      '{32'h0000_0100, NOP_W},
      '{32'h0000_0102, NOP_W},
      '{32'hFFFF_FFFC, NOP_W}
    };
    for (int i = 0; i < 7; i++) fetch(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back sequential fetches with the request held high
    for (int i = 0; i < 6; i++) sb.push_back(model_word(32'(i * 4)));
    @(posedge clk); #1;
    instr_read = 1'b1; instr_mem_address = 32'h0;
    wait_pulse(20, n);
    check("b2b_first_latency", n, LAT + 1);
    for (int i = 1; i < 6; i++) begin
      instr_mem_address = 32'(i * 4);
      wait_pulse(20, n);
      check($sformatf("b2b_period%0d", i), n, LAT + 1);
    end
    instr_read = 1'b0;
    @(negedge clk);
    check("b2b_count", {16'd0, resp_count}, {16'd0, exp_count});

    // Drop the request in WAIT: abort, no pulse, count unchanged
    cnt_before = resp_count;
    @(posedge clk); #1;
    instr_read = 1'b1; instr_mem_address = 32'h4;
    @(negedge clk); @(negedge clk);
    check("abort_busy_wait", {31'd0, busy}, 32'd1);
    instr_read = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_idle", {31'd0, busy}, 32'd0);
    check("abort_count", {16'd0, resp_count}, {16'd0, cnt_before});

    // Retarget in WAIT: one pulse, two edges after the change, with the new word
    @(posedge clk); #1;
    instr_read = 1'b1; instr_mem_address = 32'h4;
    @(negedge clk); @(negedge clk);
    sb.push_back(model_word(32'h8));
    instr_mem_address = 32'h8;
    wait_pulse(20, n);
    check("retarget_latency", n, 2);
    instr_read = 1'b0;
    repeat (4) @(negedge clk);

    // Preload write colliding with the RESP capture returns the old word
    sb.push_back(tb_mem[4]);
    @(posedge clk); #1;
    instr_read = 1'b1; instr_mem_address = 32'h10;
    @(negedge clk); @(negedge clk);
    load_en = 1'b1; load_addr = 6'd4; load_data = 32'hDEAD_BEEF;
    wait_pulse(20, n);
    check("collide_latency", n, 1);
    load_en = 1'b0;
    instr_read = 1'b0;
    tb_mem[4] = 32'hDEAD_BEEF;
    fetch(32'h10, 32'hDEAD_BEEF, "after_collide");

    // Reset during WAIT: outputs clear at once, no pulse later, memory intact
    @(posedge clk); #1;
    instr_read = 1'b1; instr_mem_address = 32'h4;
    @(negedge clk); @(negedge clk);
    held = in;
    check("pre_reset_in_nonzero", {31'd0, held != 32'd0}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_resp", {31'd0, instr_mem_resp}, 32'd0);
    check("reset_in", in, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_count", {16'd0, resp_count}, 32'd0);
    exp_count = 16'd0;
    instr_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_count", {16'd0, resp_count}, 32'd0);
    fetch(32'h0, 32'h000170b3, "post_reset_w0");
    fetch(32'h14, 32'h0000006f, "post_reset_w5");
    @(negedge clk);
    check("final_count", {16'd0, resp_count}, {16'd0, exp_count});
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning edges from request acceptance to the response cycle; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words stored.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; these ports are fixed as follows.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 instr_read  input  1  fetch request, held by requester until response.
REQ-007 instr_mem_address  input  32  byte address of the requested instruction.
REQ-008 instr_mem_resp  output  1  one-cycle pulse; in is valid this cycle.
REQ-009 in  output  32  returned instruction word.
REQ-010 load_en  input  1  preload write strobe.
REQ-011 load_addr  input  $clog2(DEPTH)  word index for the preload write.
REQ-012 load_data  input  32  preload word.
REQ-013 busy  output  1  high in WAIT or RESP.
REQ-014 resp_count  output  16  count of completed responses.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 In IDLE, instr_read=1 at an edge SHALL latch instr_mem_address and go to RESP if LATENCY=1, otherwise to WAIT with cnt=LATENCY-2.
REQ-017 In WAIT, cnt=0 with instr_read=1 SHALL go to RESP; otherwise cnt SHALL decrement.
REQ-018 instr_mem_resp SHALL be 1 only in RESP, for exactly one cycle, LATENCY edges after acceptance.
REQ-019 RESP SHALL always return to IDLE; a request still high is re-accepted on the next IDLE edge, giving back-to-back period LATENCY+1.
REQ-020 in SHALL equal mem[latched_addr[log2(DEPTH)+1:2]] captured on the WAIT/IDLE->RESP edge, and SHALL hold that value until the next RESP.
REQ-021 Address bits [1:0] SHALL be ignored; word index = addr>>2.
REQ-022 A word index >= DEPTH SHALL return 32'h00000013 (NOP).
REQ-023 instr_read falling in WAIT SHALL abort to IDLE with no response and no count increment.
REQ-024 instr_mem_address differing from the latched value in WAIT SHALL abort and re-accept: new address latched, counter reloaded, state stays WAIT.
REQ-025 load_en SHALL write load_data at the edge, in any state; load_en and a RESP capture of the same word on the same edge SHALL return the old word.
REQ-026 resp_count SHALL increment on each RESP cycle and wrap 16'hFFFF->0.

Reset
REQ-027 reset_n=0 SHALL immediately force: state IDLE, instr_mem_resp 0, in 32'h0, busy 0, resp_count 0, cnt 0, latched address 0.
REQ-028 Reset asserted during WAIT or RESP SHALL drop the pending response with no pulse after release.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 The NOP constant, the state enum and the DEPTH default SHALL reside in the shared package imem_types.
REQ-031 Storage SHALL be a sub-module imem_array: 1 sync write port, 1 read port.

Verification
REQ-032 Preload word 0=32'h000170b3; request 0x0 held high -> resp pulse 2 edges later with in=32'h000170b3; resp_count=1.
REQ-033 Six words preloaded; request 0x0..0x14 sequentially -> six pulses, 3-cycle period, data in order.
REQ-034 Request 0x100 (index 64) -> resp with in=32'h00000013.
REQ-035 Request 0x4, drop instr_read in WAIT -> no pulse; resp_count unchanged.
REQ-036 Request 0x4, change address to 0x8 in WAIT -> single pulse 2 edges after the change, with the word for 0x8.
REQ-037 Assert reset_n=0 in WAIT -> outputs zero at once; no pulse after release; preloaded data intact on next fetch.
